// File: rtl/ppu_pkg.sv
// Shared PPU bus constants: responder FSM encodings, address-map boundaries and decode helpers.
package ppu_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [13:0] CHR_END  = 14'h1FFF;
  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  typedef enum logic [1:0] {
    REG_CHR  = 2'd0,
    REG_VRAM = 2'd1,
    REG_PAL  = 2'd2
  } region_e;

  function automatic region_e decode_region(input logic [13:0] addr);
    if (addr <= CHR_END) return REG_CHR;
    if (addr >= NT_BASE && addr < PAL_BASE) return REG_VRAM;
    return REG_PAL;
  endfunction

  // 0x3000-0x3EFF (and the palette's 0x2Fxx shadow) share bits [11:0] with 0x2000-0x2EFF.
  function automatic logic [10:0] nt_index(input logic [11:0] addr, input logic vertical);
    return {(vertical ? addr[10] : addr[11]), addr[9:0]};
  endfunction

endpackage

// File: rtl/ppu_vram_responder_if.sv
// Renderer and CPU request/response channels into the PPU VRAM responder.
interface ppu_vram_responder_if;

  logic [13:0] rnd_addr;
  logic        rnd_rd_req;
  logic        rnd_wr_req;
  logic [7:0]  rnd_wdata;
  logic [7:0]  rnd_rdata;
  logic        rnd_ack;

  logic [13:0] cpu_addr;
  logic        cpu_rd_req;
  logic        cpu_wr_req;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  modport master (
    output rnd_addr, rnd_rd_req, rnd_wr_req, rnd_wdata,
    input  rnd_rdata, rnd_ack,
    output cpu_addr, cpu_rd_req, cpu_wr_req, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  rnd_addr, rnd_rd_req, rnd_wr_req, rnd_wdata,
    output rnd_rdata, rnd_ack,
    input  cpu_addr, cpu_rd_req, cpu_wr_req, cpu_wdata,
    output cpu_rdata, cpu_ack
  );

endinterface

// File: rtl/ppu_palette_ram.sv
// 32x6 palette RAM: synchronous write, combinational read, sprite backdrop entries folded onto BG ones.
module ppu_palette_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] addr,
  input  logic [5:0] wdata,
  output logic [5:0] rdata
);

  logic [5:0] mem [32];
  logic [4:0] idx;

  // 0x10/0x14/0x18/0x1C land on 0x00/0x04/0x08/0x0C.
  assign idx = (addr[1:0] == 2'b00) ? {1'b0, addr[3:0]} : addr;

  // NOTE: palette storage is deliberately not reset; contents persist through rst like real PPU palette RAM.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ppu_vram_responder.sv
// PPU bus responder: renderer-priority arbiter serving CHR, nametable VRAM and palette with the $2007 read buffer.
// Optional CHR-RAM write port enabled by defining PPU_CHR_RAM_EN.
module ppu_vram_responder
  import ppu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  ppu_vram_responder_if.slave bus,
  input  logic                mirror_vertical,
  output logic [12:0]         chr_addr,
  input  logic [7:0]          chr_rdata,
`ifdef PPU_CHR_RAM_EN
  output logic                chr_we,
  output logic [7:0]          chr_wdata,
`endif
  output logic [10:0]         vram_addr,
  output logic                vram_we,
  output logic [7:0]          vram_wdata,
  input  logic [7:0]          vram_rdata
);

  logic [1:0] state;
  logic       owner_cpu;
  logic       is_wr;
  region_e    region_q;
  logic [4:0] pal_idx;
  logic [7:0] read_buf;
  logic [7:0] rnd_rdata_q;
  logic [7:0] cpu_rdata_q;
  logic       rnd_ack_q;
  logic       cpu_ack_q;

  logic        rnd_req;
  logic        cpu_req;
  logic        take_cpu;
  logic        sel_wr;
  logic [13:0] sel_addr;
  logic [7:0]  sel_wdata;
  region_e     sel_region;

  // A port whose ack is currently pulsing is still holding its finished request; ignore it.
  assign rnd_req    = (bus.rnd_rd_req | bus.rnd_wr_req) & ~rnd_ack_q;
  assign cpu_req    = (bus.cpu_rd_req | bus.cpu_wr_req) & ~cpu_ack_q;
  assign take_cpu   = cpu_req & ~rnd_req;
  assign sel_addr   = take_cpu ? bus.cpu_addr   : bus.rnd_addr;
  assign sel_wr     = take_cpu ? bus.cpu_wr_req : bus.rnd_wr_req;
  assign sel_wdata  = take_cpu ? bus.cpu_wdata  : bus.rnd_wdata;
  assign sel_region = decode_region(sel_addr);

  logic       pal_we;
  logic [5:0] pal_rdata;
  logic [7:0] pal_byte;
  logic [7:0] fetched;
  logic [7:0] direct;

  assign pal_we = (state == ST_ACCESS) && is_wr && (region_q == REG_PAL);

  ppu_palette_ram u_palette (
    .clk   (clk),
    .we    (pal_we),
    .addr  (pal_idx),
    .wdata (vram_wdata[5:0]),
    .rdata (pal_rdata)
  );

  assign pal_byte = {2'b00, pal_rdata};
  assign fetched  = (region_q == REG_CHR) ? chr_rdata : vram_rdata;
  assign direct   = (region_q == REG_PAL) ? pal_byte : fetched;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner_cpu   <= 1'b0;
      is_wr       <= 1'b0;
      region_q    <= REG_CHR;
      pal_idx     <= 5'd0;
      read_buf    <= 8'h00;
      rnd_rdata_q <= 8'h00;
      cpu_rdata_q <= 8'h00;
      rnd_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      chr_addr    <= 13'd0;
      vram_addr   <= 11'd0;
      vram_we     <= 1'b0;
      vram_wdata  <= 8'h00;
`ifdef PPU_CHR_RAM_EN
      chr_we      <= 1'b0;
`endif
    end else begin
      // NOTE: pulses default low every cycle so each is high for exactly one cycle.
      rnd_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      vram_we   <= 1'b0;
`ifdef PPU_CHR_RAM_EN
      chr_we    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rnd_req || cpu_req) begin
            state      <= ST_ACCESS;
            owner_cpu  <= take_cpu;
            is_wr      <= sel_wr;
            region_q   <= sel_region;
            pal_idx    <= sel_addr[4:0];
            chr_addr   <= sel_addr[12:0];
            vram_addr  <= nt_index(sel_addr[11:0], mirror_vertical);
            vram_wdata <= sel_wdata;
            vram_we    <= sel_wr && (sel_region == REG_VRAM);
`ifdef PPU_CHR_RAM_EN
            chr_we     <= sel_wr && (sel_region == REG_CHR);
`endif
          end
        end
        ST_ACCESS: state <= ST_RESP;
        ST_RESP: begin
          state <= ST_IDLE;
          if (!owner_cpu) begin
            rnd_ack_q <= 1'b1;
            if (!is_wr) rnd_rdata_q <= direct;
          end else begin
            cpu_ack_q <= 1'b1;
            if (!is_wr) begin
              // Palette reads bypass the buffer, which instead picks up the nametable byte underneath.
              if (region_q == REG_PAL) begin
                cpu_rdata_q <= pal_byte;
                read_buf    <= vram_rdata;
              end else begin
                cpu_rdata_q <= read_buf;
                read_buf    <= fetched;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PPU_CHR_RAM_EN
  assign chr_wdata = vram_wdata;
`endif

  assign bus.rnd_rdata = rnd_rdata_q;
  assign bus.rnd_ack   = rnd_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;

endmodule

// File: tb/tb_ppu_vram_responder.sv
// Randomized bench for ppu_vram_responder against a PPU address-space model.
module tb_ppu_vram_responder;
  import ppu_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_clr;
  logic        mirror_vertical;
  logic [12:0] chr_addr;
  logic [7:0]  chr_rdata;
  logic [10:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
`ifdef PPU_CHR_RAM_EN
  logic        chr_we;
  logic [7:0]  chr_wdata;
`endif

  ppu_vram_responder_if bus ();

  ppu_vram_responder dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .mirror_vertical (mirror_vertical),
    .chr_addr        (chr_addr),
    .chr_rdata       (chr_rdata),
`ifdef PPU_CHR_RAM_EN
    .chr_we          (chr_we),
    .chr_wdata       (chr_wdata),
`endif
    .vram_addr       (vram_addr),
    .vram_we         (vram_we),
    .vram_wdata      (vram_wdata),
    .vram_rdata      (vram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // CHR ROM content is a fixed function of address (0x1000 holds 0x77).
  function automatic logic [7:0] chr_byte(input int a);
    logic [12:0] c;
    c = 13'(a);
    return c[7:0] ^ {3'b000, c[12:8]} ^ 8'h67;
  endfunction

  logic [7:0] vram_mem [2048];
  always @(posedge clk) begin
    chr_rdata <= chr_byte(int'(chr_addr));
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) vram_mem[i] <= 8'h00;
    end else begin
      vram_rdata <= vram_mem[vram_addr];
      if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] m_vram [2048];
  logic [5:0] m_pal  [32];
  logic [7:0] m_buf, m_rnd, m_cpu;

  function automatic int region_of(input int a);
    if (a < 'h2000) return 0;
    if (a < 'h3F00) return 1;
    return 2;
  endfunction

  function automatic int nt_phys(input int a, input bit vert);
    int off, tbl, t;
    off = (a - 'h2000) % 'h1000;
    tbl = off / 'h400;
    t   = vert ? tbl % 2 : tbl / 2;
    return t * 'h400 + off % 'h400;
  endfunction

  function automatic int pal_index(input int a);
    int i;
    i = a % 32;
    if (i % 4 == 0) i = i % 16;
    return i;
  endfunction

  task automatic model_apply(input bit cpu, input bit wr, input int a, input logic [7:0] wd);
    int kind;
    int pi;
    logic [7:0] d;
    kind = region_of(a);
    pi   = pal_index(a);
    if (kind == 0)      d = chr_byte(a);
    else if (kind == 1) d = m_vram[nt_phys(a, mirror_vertical)];
    else                d = {2'b00, m_pal[pi]};
    if (wr) begin
      if (kind == 1)      m_vram[nt_phys(a, mirror_vertical)] = wd;
      else if (kind == 2) m_pal[pi] = wd[5:0];
    end else if (!cpu) begin
      m_rnd = d;
    end else if (kind == 2) begin
      m_cpu = d;
      m_buf = m_vram[nt_phys(a & 'h2FFF, mirror_vertical)];
    end else begin
      m_cpu = m_buf;
      m_buf = d;
    end
  endtask

  // ---------------- checking ----------------
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    bus.rnd_addr = 14'd0; bus.rnd_rd_req = 1'b0; bus.rnd_wr_req = 1'b0; bus.rnd_wdata = 8'h00;
    bus.cpu_addr = 14'd0; bus.cpu_rd_req = 1'b0; bus.cpu_wr_req = 1'b0; bus.cpu_wdata = 8'h00;
  endtask

  // One complete transaction on one port; called #1 after a rising edge.
  task automatic do_txn(input bit cpu, input bit rd, input bit wr, input logic [13:0] addr,
                        input logic [7:0] wd);
    int cyc;
    bit got_ack;
    int kind;
    kind = region_of(int'(addr));
    if (cpu) begin
      bus.cpu_addr = addr; bus.cpu_rd_req = rd; bus.cpu_wr_req = wr; bus.cpu_wdata = wd;
    end else begin
      bus.rnd_addr = addr; bus.rnd_rd_req = rd; bus.rnd_wr_req = wr; bus.rnd_wdata = wd;
    end
    cyc = 0;
    got_ack = 1'b0;
    while (!got_ack && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check("vram_we", 32'(vram_we), 32'(wr && kind == 1));
        if (kind == 1) check("vram_addr", 32'(vram_addr), nt_phys(int'(addr), mirror_vertical));
        if (kind == 2 && !wr) check("vram_addr_pal", 32'(vram_addr),
                                    nt_phys(int'(addr) & 'h2FFF, mirror_vertical));
        if (kind == 0) check("chr_addr", 32'(chr_addr), 32'(addr[12:0]));
      end
      if (cyc == 2) check("vram_we_off", 32'(vram_we), 0);
      got_ack = cpu ? bus.cpu_ack : bus.rnd_ack;
      check("other_ack", 32'(cpu ? bus.rnd_ack : bus.cpu_ack), 0);
    end
    check("ack_latency", cyc, 3);
    idle_inputs();
    model_apply(cpu, wr, int'(addr), wd);
    check("rnd_rdata", 32'(bus.rnd_rdata), 32'(m_rnd));
    check("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cpu));
    @(posedge clk); #1;
    check("ack_pulse", 32'(cpu ? bus.cpu_ack : bus.rnd_ack), 0);
  endtask

  initial begin
    int rnd_at, cpu_at, rnd_cnt, cpu_cnt, cyc;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    mem_clr = 1'b1;
    mirror_vertical = 1'b0;
    idle_inputs();
    for (int i = 0; i < 2048; i++) m_vram[i] = 8'h00;
    m_buf = 8'h00; m_rnd = 8'h00; m_cpu = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    check("rst_rnd_ack", 32'(bus.rnd_ack), 0);
    check("rst_cpu_ack", 32'(bus.cpu_ack), 0);
    check("rst_vram_we", 32'(vram_we), 0);
    check("rst_rnd_rdata", 32'(bus.rnd_rdata), 0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check("rst_vram_addr", 32'(vram_addr), 0);
    check("rst_chr_addr", 32'(chr_addr), 0);
    rst = 1'b0;
    mem_clr = 1'b0;

    // Fill the palette so every entry is known to the model.
    for (int i = 0; i < 32; i++) do_txn(1'b1, 1'b0, 1'b1, 14'h3F00 + 14'(i), 8'($urandom));

    // Buffered CHR reads: first returns the post-reset buffer, second the fetched byte.
    do_txn(1'b1, 1'b1, 1'b0, 14'h1000, 8'h00);
    check("chr_first", 32'(bus.cpu_rdata), 32'h00);
    do_txn(1'b1, 1'b1, 1'b0, 14'h1000, 8'h00);
    check("chr_second", 32'(bus.cpu_rdata), 32'h77);

    // Renderer read under vertical mirroring.
    mirror_vertical = 1'b1;
    do_txn(1'b1, 1'b0, 1'b1, 14'h2005, 8'h5A);
    do_txn(1'b0, 1'b1, 1'b0, 14'h2005, 8'h00);
    check("rnd_2005", 32'(bus.rnd_rdata), 32'h5A);

    // Horizontal mirroring: 0x2400 aliases 0x2000.
    mirror_vertical = 1'b0;
    do_txn(1'b1, 1'b0, 1'b1, 14'h2400, 8'h11);
    do_txn(1'b0, 1'b1, 1'b0, 14'h2000, 8'h00);
    check("rnd_mirror", 32'(bus.rnd_rdata), 32'h11);

    // Palette alias write and direct read; buffer picks up VRAM 0x2F00.
    do_txn(1'b1, 1'b0, 1'b1, 14'h2F00, 8'h3C);
    do_txn(1'b1, 1'b0, 1'b1, 14'h3F10, 8'h2C);
    do_txn(1'b1, 1'b1, 1'b0, 14'h3F00, 8'h00);
    check("pal_alias", 32'(bus.cpu_rdata), 32'h2C);
    do_txn(1'b1, 1'b1, 1'b0, 14'h2000, 8'h00);
    check("pal_buf", 32'(bus.cpu_rdata), 32'h3C);

    // rd and wr together act as a write.
    do_txn(1'b1, 1'b1, 1'b1, 14'h2100, 8'hC3);
    do_txn(1'b0, 1'b1, 1'b0, 14'h2100, 8'h00);
    check("rdwr_is_write", 32'(bus.rnd_rdata), 32'hC3);

    // Simultaneous requests: renderer first, CPU three cycles later.
    bus.rnd_addr = 14'h2005; bus.rnd_rd_req = 1'b1;
    bus.cpu_addr = 14'h1000; bus.cpu_rd_req = 1'b1;
    rnd_at = 0; cpu_at = 0; rnd_cnt = 0; cpu_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (bus.rnd_ack) begin rnd_cnt++; if (rnd_at == 0) rnd_at = c; bus.rnd_rd_req = 1'b0; end
      if (bus.cpu_ack) begin cpu_cnt++; if (cpu_at == 0) cpu_at = c; bus.cpu_rd_req = 1'b0; end
    end
    idle_inputs();
    check("both_rnd_at", rnd_at, 3);
    check("both_cpu_at", cpu_at, 6);
    check("both_rnd_cnt", rnd_cnt, 1);
    check("both_cpu_cnt", cpu_cnt, 1);
    model_apply(1'b0, 1'b0, 'h2005, 8'h00);
    model_apply(1'b1, 1'b0, 'h1000, 8'h00);
    check("both_rnd_rdata", 32'(bus.rnd_rdata), 32'(m_rnd));
    check("both_cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cpu));

    // Reset during ACCESS drops the write; the still-held request is served fresh afterwards.
    bus.cpu_addr = 14'h2123; bus.cpu_wr_req = 1'b1; bus.cpu_wdata = 8'hAB;
    @(posedge clk); #1;
    check("inflight_we", 32'(vram_we), 1);
    rst = 1'b1;
    #1;
    check("rst_we_now", 32'(vram_we), 0);
    check("rst_idle_now", 32'(dut.state), 32'(ST_IDLE));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst_no_ack", 32'(bus.cpu_ack | bus.rnd_ack), 0);
    end
    m_buf = 8'h00; m_rnd = 8'h00; m_cpu = 8'h00;
    check("rst_cpu_rdata_clr", 32'(bus.cpu_rdata), 32'(m_cpu));
    rst = 1'b0;
    cyc = 0;
    while (!bus.cpu_ack && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("fresh_latency", cyc, 3);
    idle_inputs();
    model_apply(1'b1, 1'b1, 'h2123, 8'hAB);
    @(posedge clk); #1;
    do_txn(1'b0, 1'b1, 1'b0, 14'h2123, 8'h00);
    check("fresh_write", 32'(bus.rnd_rdata), 32'hAB);

    // Random traffic over the whole map.
    for (int t = 0; t < 300; t++) begin
      bit cpu, rd, wr;
      int r;
      logic [13:0] a;
      cpu = 1'($urandom);
      rd  = 1'($urandom);
      wr  = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      r = int'($urandom_range(0, 3));
      if (r == 0)      a = 14'($urandom_range(0, 'h1FFF));
      else if (r == 3) a = 14'($urandom_range('h3F00, 'h3FFF));
      else             a = 14'($urandom_range('h2000, 'h3EFF));
`ifdef PPU_CHR_RAM_EN
      if (r == 0) wr = 1'b0;
      if (!rd && !wr) rd = 1'b1;
`endif
      if ((t % 16) == 0) mirror_vertical = 1'($urandom);
      do_txn(cpu, rd, wr, a, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ppu_vram_responder.md
PPU_VRAM_RESPONDER -- requirements
Module: ppu_vram_responder

Interface
REQ-001 SHALL have ports clk, in, 1, 25 MHz system clock; and rst, in, 1, reset, asynchronous and active-high.
REQ-002 SHALL have rnd_addr, in, 14, renderer PPU address; and rnd_rd_req, in, 1, renderer read request, held until ack.
REQ-003 SHALL have rnd_wr_req, in, 1, renderer write request; and rnd_wdata, in, 8, renderer write data.
REQ-004 SHALL have rnd_rdata, out, 8, renderer read data; and rnd_ack, out, 1, one-cycle completion pulse.
REQ-005 SHALL have cpu_addr, in, 14, $2006/$2007 address; cpu_rd_req, in, 1; cpu_wr_req, in, 1; and cpu_wdata, in, 8.
REQ-006 SHALL have cpu_rdata, out, 8, $2007 read value; and cpu_ack, out, 1, one-cycle completion pulse.
REQ-007 SHALL have mirror_vertical, in, 1, nametable mirroring select, 1 = vertical and 0 = horizontal.
REQ-008 SHALL have chr_addr, out, 13; and chr_rdata, in, 8; CHR memory has a synchronous 1-cycle read.
REQ-009 SHALL have vram_addr, out, 11; vram_we, out, 1; vram_wdata, out, 8; and vram_rdata, in, 8; the 2 KB VRAM has a synchronous 1-cycle read.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS and RESP; transitions are IDLE to ACCESS on any request, ACCESS to RESP unconditionally, and RESP to IDLE unconditionally.
REQ-011 SHALL, in IDLE, grant the renderer when both ports request in the same cycle; the CPU request stays pending and is served on the next IDLE.
REQ-012 SHALL latch the address, data, direction and owner on the IDLE-to-ACCESS edge; memory address outputs are registered.
REQ-013 SHALL treat a request with both rd and wr high as a write.
REQ-014 SHALL pulse the owner's ack in the cycle after RESP: request seen in cycle 0 gives ack in cycle 3; the other ack stays 0.
REQ-015 SHALL register rdata together with ack and hold it until the next ack on that port.
REQ-016 SHALL decode 0x0000-0x1FFF as CHR with chr_addr = addr[12:0].
REQ-017 SHALL decode 0x2000-0x3EFF as VRAM; vertical mirroring gives {addr[10],addr[9:0]}, horizontal gives {addr[11],addr[9:0]}; 0x3000-0x3EFF mirrors 0x2000.
REQ-018 SHALL decode 0x3F00-0x3FFF as the internal 32x6 palette indexed by addr[4:0], with 0x10/0x14/0x18/0x1C aliased to 0x00/0x04/0x08/0x0C; palette reads return {2'b00,data}.
REQ-019 SHALL assert vram_we for exactly the one ACCESS cycle of a VRAM write; palette writes store wdata[5:0] in that cycle.
REQ-020 SHALL give renderer reads the direct data.
REQ-021 SHALL give CPU reads below 0x3F00 the previous read-buffer content, and then load the buffer with the fetched byte.
REQ-022 SHALL give CPU palette reads the palette value directly, and load the buffer with the VRAM byte at addr & 0x2FFF.
REQ-023 SHALL ack CPU writes without changing cpu_rdata or the buffer.

Reset
REQ-024 SHALL, while rst is high, force the state to IDLE; rnd_ack, cpu_ack, vram_we = 0; and rnd_rdata, cpu_rdata, read buffer, chr_addr, vram_addr, vram_wdata = 0.
REQ-025 SHALL NOT reset palette contents.
REQ-026 SHALL silently drop a transaction in flight at reset with no ack; a request still held after reset release is served fresh.

Configuration
REQ-027 SHALL, when PPU_CHR_RAM_EN is defined, add outputs chr_we (1) and chr_wdata (8); CHR writes then pulse chr_we for one ACCESS cycle.
REQ-028 SHALL, when PPU_CHR_RAM_EN is undefined, have no chr_we/chr_wdata ports; CHR writes are acked and discarded.

Structure
REQ-029 SHALL take the FSM state encodings and address-range constants (CHR_END, NT_BASE, PAL_BASE) from shared package ppu_pkg.
REQ-030 SHALL implement the palette in sub-module ppu_palette_ram: 32x6, synchronous write, combinational read, alias folding internal.

Verification
REQ-031 SHALL check: renderer read 0x2005 with vertical mirroring and vram_rdata = 0x5A -> vram_addr = 0x005, rnd_ack 3 cycles after request, rnd_rdata = 0x5A.
REQ-032 SHALL check: CPU writes 0x11 to 0x2400 under horizontal mirroring, then renderer reads 0x2000 -> vram_we pulse at vram_addr = 0x000, read returns 0x11.
REQ-033 SHALL check: CPU writes 0x2C to 0x3F10, then reads 0x3F00 -> cpu_rdata = 0x2C, buffer loaded from VRAM 0x2F00.
REQ-034 SHALL check: two CPU reads of 0x1000 with chr_rdata = 0x77 -> first cpu_rdata = old buffer (0x00 after reset), second = 0x77.
REQ-035 SHALL check: renderer and CPU request in the same cycle -> rnd_ack first, cpu_ack 3 cycles later, each pulse one cycle.
REQ-036 SHALL check: rst asserted in ACCESS -> no ack, vram_we = 0 immediately, state IDLE.
